// File: rtl/wrapping_step_counter.sv
// Modulo-RANGE up/down counter advancing or retreating by 0..MAX_STEP per cycle, with lap bit and wrap pulses.
// Latency: 1 cycle; count, lap and wrap pulses are all registered.
// Backpressure: none; every control input is sampled on each rising clock edge.
module wrapping_step_counter #(
  parameter int RANGE       = 5,
  parameter int RANGE_LOG2  = $clog2(RANGE),
  parameter int MAX_STEP    = 3,
  parameter int STEP_WIDTH  = $clog2(MAX_STEP + 1),
  parameter int RESET_VALUE = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [RANGE_LOG2-1:0] load_value,
  input  logic                  increment,
  input  logic                  decrement,
  input  logic [STEP_WIDTH-1:0] step,
  output logic [RANGE_LOG2-1:0] count,
  output logic                  lap,
  output logic                  wrapped_up,
  output logic                  wrapped_down
);

  // One extra bit holds the carry/borrow of count +/- step.
  localparam int W1 = RANGE_LOG2 + 1;
  localparam bit IS_POW2 = ((RANGE & (RANGE - 1)) == 0);
  localparam logic [W1-1:0]         RANGE_W1   = W1'(RANGE);
  localparam logic [RANGE_LOG2-1:0] RANGE_M1   = RANGE_LOG2'(RANGE - 1);
  localparam logic [RANGE_LOG2-1:0] RESET_N    = RANGE_LOG2'(RESET_VALUE);
  localparam logic [STEP_WIDTH-1:0] MAX_STEP_S = STEP_WIDTH'(MAX_STEP);

  logic [RANGE_LOG2-1:0] count_q, count_d;
  logic                  lap_q, lap_d;
  logic                  wrapped_up_q, wrapped_up_d;
  logic                  wrapped_down_q, wrapped_down_d;

  logic [STEP_WIDTH-1:0] step_c;
  logic [W1-1:0]         step_w1;
  logic [RANGE_LOG2-1:0] load_sat;
  logic [RANGE_LOG2-1:0] inc_val, dec_val;
  logic                  inc_wrap, dec_wrap;

  // Clamp illegal steps to MAX_STEP and saturate out-of-range load values.
  always_comb begin
    step_c   = (step > MAX_STEP_S) ? MAX_STEP_S : step;
    step_w1  = W1'(step_c);
    load_sat = ({1'b0, load_value} >= RANGE_W1) ? RANGE_M1 : load_value;
  end

  if (IS_POW2) begin : g_pow2
    logic [W1-1:0] sum;
    logic [W1-1:0] diff;
    // Power-of-2 range: the wrap condition is simply the carry or borrow bit.
    always_comb begin
      sum      = {1'b0, count_q} + step_w1;
      diff     = {1'b0, count_q} - step_w1;
      inc_wrap = sum[RANGE_LOG2];
      inc_val  = sum[RANGE_LOG2-1:0];
      dec_wrap = diff[RANGE_LOG2];
      dec_val  = diff[RANGE_LOG2-1:0];
    end
  end else begin : g_general
    // RANGE is below 2^RANGE_LOG2 here, so it and any legal step fit in RANGE_LOG2 bits.
    localparam logic [RANGE_LOG2-1:0] RANGE_N = RANGE_LOG2'(RANGE);
    logic [W1-1:0]         sum;
    logic [RANGE_LOG2-1:0] step_n;
    // Arbitrary range: compare against RANGE; modular narrow arithmetic is exact since results lie in [0, RANGE).
    always_comb begin
      sum      = {1'b0, count_q} + step_w1;
      step_n   = step_w1[RANGE_LOG2-1:0];
      inc_wrap = (sum >= RANGE_W1);
      inc_val  = inc_wrap ? (count_q + step_n - RANGE_N) : sum[RANGE_LOG2-1:0];
      dec_wrap = (count_q < step_n);
      dec_val  = dec_wrap ? (count_q + RANGE_N - step_n) : (count_q - step_n);
    end
  end

  // Next-state selection: clear beats load beats a lone increment or decrement.
  always_comb begin
    count_d        = count_q;
    lap_d          = lap_q;
    wrapped_up_d   = 1'b0;
    wrapped_down_d = 1'b0;
    if (clear) begin
      count_d = RESET_N;
      lap_d   = 1'b0;
    end else if (load) begin
      count_d = load_sat;
      lap_d   = 1'b0;
    end else if (increment && !decrement) begin
      count_d = inc_val;
      if (inc_wrap) begin
        lap_d        = ~lap_q;
        wrapped_up_d = 1'b1;
      end
    end else if (decrement && !increment) begin
      count_d = dec_val;
      if (dec_wrap) begin
        lap_d          = ~lap_q;
        wrapped_down_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q        <= RESET_N;
      lap_q          <= 1'b0;
      wrapped_up_q   <= 1'b0;
      wrapped_down_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      lap_q          <= lap_d;
      wrapped_up_q   <= wrapped_up_d;
      wrapped_down_q <= wrapped_down_d;
    end
  end

  assign count        = count_q;
  assign lap          = lap_q;
  assign wrapped_up   = wrapped_up_q;
  assign wrapped_down = wrapped_down_q;

`ifndef SYNTHESIS
  // A step above MAX_STEP is a caller bug; the datapath clamps it anyway.
  a_step_legal: assert property (@(posedge clock) disable iff (!resetn)
    (!clear && !load && (increment ^ decrement)) |-> (step <= MAX_STEP_S))
    else $error("wrapping_step_counter: step %0d exceeds MAX_STEP %0d", step, MAX_STEP);
`endif

endmodule
